// File: rtl/eth_rgmii_rx_framer.sv
// RGMII receive framer: in-band status decode, preamble/SFD strip, byte
// assembly for 1000 (DDR byte) and 10/100 (SDR nibble), saturating stats.
module eth_rgmii_rx_framer #(
    parameter bit          SPEED_AUTO   = 1'b1,
    parameter logic [1:0]  FORCE_SPEED  = 2'b10,
    parameter int unsigned MAX_PREAMBLE = 15,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             rx_clk,
    input  logic             rst_n,
    input  logic             in_ctl0,
    input  logic             in_ctl1,
    input  logic [7:0]       in_data,
    output logic             rx_valid,
    output logic [7:0]       rx_data,
    output logic             rx_sof,
    output logic             rx_eof,
    output logic             rx_error,
    output logic             link_up,
    output logic [1:0]       link_speed,
    output logic             link_full_duplex,
    output logic [CNT_W-1:0] stat_frames,
    output logic [CNT_W-1:0] stat_errors
);

    // Preamble is counted in units (bytes at 1000, nibbles at 10/100).
    localparam int unsigned PRE_LIM_NIB = 2 * MAX_PREAMBLE;
    localparam int unsigned PRE_W       = $clog2(PRE_LIM_NIB + 2);

    typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_DROP} state_t;

    state_t             state_q, state_d;
    logic               mode_gbe_q, mode_gbe_d;
    logic [PRE_W-1:0]   pre_cnt_q, pre_cnt_d;
    logic               phase_q, phase_d;
    logic [3:0]         lo_nib_q, lo_nib_d;
    logic               sticky_q, sticky_d;
    logic               hold_valid_q, hold_valid_d;
    logic [7:0]         hold_data_q, hold_data_d;
    logic               hold_sof_q, hold_sof_d;
    logic               armed_q, armed_d;

    logic               out_valid_d, out_sof_d, out_eof_d, out_err_d;
    logic [7:0]         out_data_d;
    logic [CNT_W-1:0]   frames_d, errors_d;

    logic               dv, er, cur_gbe;
    logic               pre_eval, byte_done, drop_evt, empty_evt, err_evt;
    logic [7:0]         byte_val;
    logic [PRE_W-1:0]   pre_base, pre_inc, pre_lim;
    logic               is_pre_unit, is_sfd_unit;

    assign dv = in_ctl0;
    assign er = in_ctl0 ^ in_ctl1;

    // Speed codes 10 and 11 both select byte mode; latched mode used once out of IDLE.
    assign cur_gbe     = (state_q == S_IDLE) ? link_speed[1] : mode_gbe_q;
    assign pre_base    = (state_q == S_PRE) ? pre_cnt_q : '0;
    assign pre_inc     = pre_base + PRE_W'(1);
    assign pre_lim     = cur_gbe ? PRE_W'(MAX_PREAMBLE) : PRE_W'(PRE_LIM_NIB);
    assign is_pre_unit = cur_gbe ? (in_data == 8'h55) : (in_data[3:0] == 4'h5);
    assign is_sfd_unit = cur_gbe ? (in_data == 8'hD5) : (in_data[3:0] == 4'hD);

    // In-band link status captured only during normal inter-frame idle.
    always_ff @(posedge rx_clk) begin
        if (!rst_n) begin
            link_up          <= 1'b0;
            link_speed       <= FORCE_SPEED;
            link_full_duplex <= 1'b0;
        end else if (!dv && !er) begin
            link_up          <= in_data[0];
            link_full_duplex <= in_data[3];
            if (SPEED_AUTO) link_speed <= in_data[2:1];
            else            link_speed <= FORCE_SPEED;
        end
    end

    // Framer state register and registered outputs/counters.
    always_ff @(posedge rx_clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            mode_gbe_q   <= 1'b0;
            pre_cnt_q    <= '0;
            phase_q      <= 1'b0;
            lo_nib_q     <= '0;
            sticky_q     <= 1'b0;
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
            hold_sof_q   <= 1'b0;
            armed_q      <= 1'b0;
            rx_valid     <= 1'b0;
            rx_data      <= '0;
            rx_sof       <= 1'b0;
            rx_eof       <= 1'b0;
            rx_error     <= 1'b0;
            stat_frames  <= '0;
            stat_errors  <= '0;
        end else begin
            state_q      <= state_d;
            mode_gbe_q   <= mode_gbe_d;
            pre_cnt_q    <= pre_cnt_d;
            phase_q      <= phase_d;
            lo_nib_q     <= lo_nib_d;
            sticky_q     <= sticky_d;
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
            hold_sof_q   <= hold_sof_d;
            armed_q      <= armed_d;
            rx_valid     <= out_valid_d;
            rx_data      <= out_data_d;
            rx_sof       <= out_sof_d;
            rx_eof       <= out_eof_d;
            rx_error     <= out_err_d;
            stat_frames  <= frames_d;
            stat_errors  <= errors_d;
        end
    end

    // Next-state, byte assembly with one-byte holdback, and counter updates.
    always_comb begin
        state_d      = state_q;
        mode_gbe_d   = mode_gbe_q;
        pre_cnt_d    = pre_cnt_q;
        phase_d      = phase_q;
        lo_nib_d     = lo_nib_q;
        sticky_d     = sticky_q;
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        hold_sof_d   = hold_sof_q;
        armed_d      = armed_q | ~dv;
        out_valid_d  = 1'b0;
        out_data_d   = rx_data;
        out_sof_d    = 1'b0;
        out_eof_d    = 1'b0;
        out_err_d    = 1'b0;
        pre_eval     = 1'b0;
        byte_done    = 1'b0;
        byte_val     = in_data;
        empty_evt    = 1'b0;

        case (state_q)
            S_IDLE: begin
                // After reset a dv=0 cycle must be seen before a frame is accepted.
                if (dv && armed_q) begin
                    mode_gbe_d = link_speed[1];
                    pre_eval   = 1'b1;
                end
            end
            S_PRE: begin
                if (!dv) state_d = S_IDLE;
                else     pre_eval = 1'b1;
            end
            S_DATA: begin
                if (dv) begin
                    if (er) sticky_d = 1'b1;
                    if (cur_gbe) begin
                        byte_done = 1'b1;
                        byte_val  = in_data;
                    end else if (!phase_q) begin
                        lo_nib_d = in_data[3:0];
                        phase_d  = 1'b1;
                    end else begin
                        byte_done = 1'b1;
                        byte_val  = {in_data[3:0], lo_nib_q};
                        phase_d   = 1'b0;
                    end
                    if (byte_done) begin
                        if (hold_valid_q) begin
                            out_valid_d = 1'b1;
                            out_data_d  = hold_data_q;
                            out_sof_d   = hold_sof_q;
                            hold_sof_d  = 1'b0;
                        end
                        hold_valid_d = 1'b1;
                        hold_data_d  = byte_val;
                    end
                end else begin
                    state_d = S_IDLE;
                    if (hold_valid_q) begin
                        out_valid_d = 1'b1;
                        out_data_d  = hold_data_q;
                        out_sof_d   = hold_sof_q;
                        out_eof_d   = 1'b1;
                        out_err_d   = sticky_q | phase_q;
                    end else begin
                        empty_evt = 1'b1;
                    end
                    hold_valid_d = 1'b0;
                    phase_d      = 1'b0;
                end
            end
            S_DROP: begin
                if (!dv) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Preamble/SFD evaluation shared by IDLE (first unit) and PRE.
        if (pre_eval) begin
            if (is_pre_unit) begin
                pre_cnt_d = pre_inc;
                state_d   = (pre_inc > pre_lim) ? S_DROP : S_PRE;
            end else if (is_sfd_unit) begin
                state_d      = S_DATA;
                phase_d      = 1'b0;
                sticky_d     = 1'b0;
                hold_valid_d = 1'b0;
                hold_sof_d   = 1'b1;
            end else begin
                state_d = S_DROP;
            end
        end

        drop_evt = (state_d == S_DROP) && (state_q != S_DROP);
        err_evt  = (out_eof_d && out_err_d) || drop_evt || empty_evt;

        frames_d = stat_frames;
        if (out_eof_d && !(&stat_frames)) frames_d = stat_frames + CNT_W'(1);
        errors_d = stat_errors;
        if (err_evt && !(&stat_errors)) errors_d = stat_errors + CNT_W'(1);
    end

endmodule

// File: tb/tb_eth_rgmii_rx_framer.sv
// Scoreboard bench for eth_rgmii_rx_framer: expected bytes queued as frames
// are driven, compared by a monitor as the framer presents them.
module tb_eth_rgmii_rx_framer;

    localparam int unsigned CNT_W = 16;

    typedef struct packed {
        logic [7:0] d;
        logic       sof;
        logic       eof;
        logic       err;
    } exp_t;

    logic             rx_clk;
    logic             rst_n;
    logic             in_ctl0, in_ctl1;
    logic [7:0]       in_data;
    logic             rx_valid, rx_sof, rx_eof, rx_error;
    logic [7:0]       rx_data;
    logic             link_up, link_full_duplex;
    logic [1:0]       link_speed;
    logic [CNT_W-1:0] stat_frames, stat_errors;

    exp_t       sb_q[$];
    logic [7:0] frame_q[$];
    int         n_checks;
    int         n_errors;
    int         exp_frames;
    int         exp_errs;

    eth_rgmii_rx_framer #(
        .SPEED_AUTO   (1'b1),
        .FORCE_SPEED  (2'b10),
        .MAX_PREAMBLE (15),
        .CNT_W        (CNT_W)
    ) dut (
        .rx_clk           (rx_clk),
        .rst_n            (rst_n),
        .in_ctl0          (in_ctl0),
        .in_ctl1          (in_ctl1),
        .in_data          (in_data),
        .rx_valid         (rx_valid),
        .rx_data          (rx_data),
        .rx_sof           (rx_sof),
        .rx_eof           (rx_eof),
        .rx_error         (rx_error),
        .link_up          (link_up),
        .link_speed       (link_speed),
        .link_full_duplex (link_full_duplex),
        .stat_frames      (stat_frames),
        .stat_errors      (stat_errors)
    );

    initial rx_clk = 1'b0;
    always #5 rx_clk = ~rx_clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] d, input logic sof, input logic eof, input logic err);
        exp_t e;
        e.d = d; e.sof = sof; e.eof = eof; e.err = err;
        return e;
    endfunction

    // Drive one RGMII sample just after the rising edge; it is captured on the next one.
    task automatic step(input logic c0, input logic c1, input logic [7:0] d);
        @(posedge rx_clk);
        #1;
        in_ctl0 = c0;
        in_ctl1 = c1;
        in_data = d;
    endtask

    task automatic idle(input int n, input logic [7:0] status);
        repeat (n) step(1'b0, 1'b0, status);
    endtask

    // 1000-mode frame from frame_q; er asserted on index er_idx (-1 for none).
    task automatic send_gbe(input int npre, input int er_idx);
        repeat (npre) step(1'b1, 1'b1, 8'h55);
        step(1'b1, 1'b1, 8'hD5);
        for (int i = 0; i < frame_q.size(); i++) begin
            sb_q.push_back(mk(frame_q[i], i == 0, i == frame_q.size() - 1, er_idx >= 0));
            step(1'b1, (i == er_idx) ? 1'b0 : 1'b1, frame_q[i]);
            if (i >= 2) check_val("latency", 32'({rx_valid, rx_data}), 32'({1'b1, frame_q[i-2]}));
        end
    endtask

    task automatic send_nib_pre(input int npre);
        repeat (npre) step(1'b1, 1'b1, 8'h05);
        step(1'b1, 1'b1, 8'h0D);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 40 && sb_q.size() != 0; i++) @(posedge rx_clk);
        check_val("drain", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic check_stats(input string tag);
        check_val({tag, "_frames"}, 32'(stat_frames), 32'(exp_frames));
        check_val({tag, "_errors"}, 32'(stat_errors), 32'(exp_errs));
    endtask

    // Output monitor: every presented byte must match the scoreboard head.
    always @(negedge rx_clk) begin
        if (rx_valid) begin
            if (sb_q.size() == 0) begin
                check_val("unexpected_valid", 32'(rx_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check_val("data", 32'(rx_data), 32'(e.d));
                check_val("sof", 32'(rx_sof), 32'(e.sof));
                check_val("eof", 32'(rx_eof), 32'(e.eof));
                if (e.eof) check_val("error", 32'(rx_error), 32'(e.err));
            end
        end
    end

    initial begin
        n_checks = 0; n_errors = 0; exp_frames = 0; exp_errs = 0;
        rst_n = 1'b0; in_ctl0 = 1'b0; in_ctl1 = 1'b0; in_data = 8'h00;
        repeat (3) step(1'b0, 1'b0, 8'h00);
        check_val("rst_valid", 32'(rx_valid), 32'd0);
        check_val("rst_speed", 32'(link_speed), 32'd2);
        check_val("rst_link", 32'({link_up, link_full_duplex}), 32'd0);
        check_stats("rst");
        rst_n = 1'b1;

        // 1000: 7x55, D5, 01..04
        idle(4, 8'h0D);
        check_val("st_gbe_up", 32'(link_up), 32'd1);
        check_val("st_gbe_speed", 32'(link_speed), 32'd2);
        check_val("st_gbe_fd", 32'(link_full_duplex), 32'd1);
        frame_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        send_gbe(7, -1);
        idle(6, 8'h0D);
        exp_frames++;
        wait_drain();
        check_stats("gbe");

        // 100M: status 0x3 then 0xB
        idle(4, 8'h03);
        check_val("st_100_speed", 32'(link_speed), 32'd1);
        check_val("st_100_hd", 32'(link_full_duplex), 32'd0);
        idle(3, 8'h0B);
        check_val("st_100_fd", 32'(link_full_duplex), 32'd1);
        sb_q.push_back(mk(8'h01, 1'b1, 1'b0, 1'b0));
        sb_q.push_back(mk(8'h02, 1'b0, 1'b1, 1'b0));
        send_nib_pre(15);
        step(1'b1, 1'b1, 8'h01); step(1'b1, 1'b1, 8'h00);
        step(1'b1, 1'b1, 8'h02); step(1'b1, 1'b1, 8'h00);
        idle(6, 8'h0B);
        exp_frames++;
        wait_drain();
        check_stats("nib100");

        // 1000 with er on byte 2 of 4
        idle(4, 8'h0D);
        frame_q = '{8'h10, 8'h20, 8'h30, 8'h40};
        send_gbe(7, 1);
        idle(6, 8'h0D);
        exp_frames++; exp_errs++;
        wait_drain();
        check_stats("er");

        // Bad SFD then a good frame
        step(1'b1, 1'b1, 8'h55); step(1'b1, 1'b1, 8'h55); step(1'b1, 1'b1, 8'hA5);
        step(1'b1, 1'b1, 8'h11); step(1'b1, 1'b1, 8'h22);
        idle(4, 8'h0D);
        exp_errs++;
        check_stats("badsfd");
        frame_q = '{8'hAA, 8'hBB};
        send_gbe(7, -1);
        idle(6, 8'h0D);
        exp_frames++;
        wait_drain();
        check_stats("after_bad");

        // Preamble at the limit is accepted; one more is dropped
        frame_q = '{8'h77};
        send_gbe(15, -1);
        idle(6, 8'h0D);
        exp_frames++;
        wait_drain();
        check_stats("pre_max");
        repeat (16) step(1'b1, 1'b1, 8'h55);
        step(1'b1, 1'b1, 8'hD5); step(1'b1, 1'b1, 8'h33);
        idle(6, 8'h0D);
        exp_errs++;
        check_stats("pre_long");

        // 10M dribble nibble
        idle(4, 8'h01);
        check_val("st_10_speed", 32'(link_speed), 32'd0);
        sb_q.push_back(mk(8'h01, 1'b1, 1'b1, 1'b1));
        send_nib_pre(15);
        step(1'b1, 1'b1, 8'h01); step(1'b1, 1'b1, 8'h00); step(1'b1, 1'b1, 8'h02);
        idle(6, 8'h01);
        exp_frames++; exp_errs++;
        wait_drain();
        check_stats("dribble");

        // Reset mid-DATA
        idle(4, 8'h0D);
        repeat (7) step(1'b1, 1'b1, 8'h55);
        step(1'b1, 1'b1, 8'hD5);
        sb_q.push_back(mk(8'hE1, 1'b1, 1'b0, 1'b0));
        step(1'b1, 1'b1, 8'hE1);
        step(1'b1, 1'b1, 8'hE2);
        step(1'b1, 1'b1, 8'hE3);
        rst_n = 1'b0;
        step(1'b1, 1'b1, 8'hE4);
        rst_n = 1'b1;
        exp_frames = 0; exp_errs = 0;
        check_val("mid_rst_valid", 32'(rx_valid), 32'd0);
        check_val("mid_rst_link", 32'(link_up), 32'd0);
        check_stats("mid_rst");
        step(1'b1, 1'b1, 8'hD5);
        step(1'b1, 1'b1, 8'hE5);
        idle(4, 8'h0D);
        check_stats("post_rst_tail");
        frame_q = '{8'h5A, 8'hA5, 8'h3C};
        send_gbe(7, -1);
        idle(6, 8'h0D);
        exp_frames++;
        wait_drain();
        check_stats("post_rst");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
